answer_generator: RTL and testbench

Produces the secret four-digit answer for a Bulls and Cows round: four distinct BCD digits packed in the same `{d1,d2,d3,d4}` nibble order as the player's guess word. It replaces the fixed `16'h1234` answer constant and feeds the game-logic block's `answer` input. The block draws digits from a free-running LFSR, mixed with keypad activity, and rejects out-of-range and duplicate digits.

---
 rtl/bnc_pkg.sv | 16 +
 rtl/answer_generator_lfsr16.sv | 30 +++
 rtl/answer_generator.sv | 123 ++++++++++++
 tb/tb_answer_generator.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnc_pkg.sv
// Shared Bulls and Cows definitions: digit width, empty-slot sentinel,
// LFSR feedback taps and the answer generator state encoding.
package bnc_pkg;

  localparam int              DIGIT_W     = 4;
  localparam int              NUM_SLOTS   = 4;
  localparam logic [DIGIT_W-1:0] EMPTY_DIGIT = 4'hF;
  localparam logic [15:0]     LFSR_TAPS   = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } gen_state_e;

endpackage

// File: rtl/answer_generator_lfsr16.sv
// 16-bit right-shifting Galois LFSR with a serial noise input and
// zero-lock protection: an all-zero next state reloads SEED.
module lfsr16
  import bnc_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        din,
  output logic [15:0] q
);

  logic [15:0] q_nxt;

  always_comb begin
    // NOTE: q_nxt is assigned unconditionally first, so no path leaves it unassigned and no latch is inferred.
    q_nxt    = {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    q_nxt[0] = q_nxt[0] ^ din;
    if (q_nxt == 16'h0000) q_nxt = SEED;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)     q <= SEED;
    else if (en) q <= q_nxt;
  end

endmodule

// File: rtl/answer_generator.sv
// Draws four distinct BCD digits from an entropy-stirred LFSR, one candidate
// per cycle, with a bounded-retry fallback to the smallest unused legal digit.
module answer_generator
  import bnc_pkg::*;
#(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter bit          ALLOW_ZERO   = 1'b1,
  parameter int          REJECT_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        entropy,
  input  logic        new_game,
  output logic        busy,
  output logic        answer_valid,
  output logic [15:0] answer
);

  gen_state_e           state, state_nxt;
  logic                 ent_meta, ent_sync;
  logic [15:0]          lfsr_q;
  logic [DIGIT_W-1:0]   slot [NUM_SLOTS];
  logic [1:0]           idx;
  logic [7:0]           rej_cnt, rej_next;
  logic [DIGIT_W-1:0]   cand, lo_digit, fb_digit, store_digit;
  logic                 dup, used, reject, store, last_store;

  // Two-flop synchronizer: entropy comes from unsynchronized keypad lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_meta <= 1'b0;
      ent_sync <= 1'b0;
    end else begin
      ent_meta <= entropy;
      ent_sync <= ent_meta;
    end
  end

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .din (ent_sync),
    .q   (lfsr_q)
  );

  assign cand = lfsr_q[DIGIT_W-1:0];

  always_comb begin
    lo_digit = ALLOW_ZERO ? 4'd0 : 4'd1;
    dup      = 1'b0;
    used     = 1'b0;
    fb_digit = EMPTY_DIGIT;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (i < int'(idx) && slot[i] == cand) dup = 1'b1;
    reject = (cand > 4'd9) || (cand < lo_digit) || dup;
    // Descending scan so the last hit, i.e. the smallest free legal digit, wins.
    for (int d = 9; d >= 0; d--) begin
      used = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++)
        if (i < int'(idx) && slot[i] == 4'(d)) used = 1'b1;
      if (4'(d) >= lo_digit && !used) fb_digit = 4'(d);
    end
    rej_next    = rej_cnt + 8'd1;
    store       = !reject || (rej_next == 8'(REJECT_LIMIT));
    store_digit = reject ? fb_digit : cand;
    last_store  = (state == DRAW) && store && (idx == 2'(NUM_SLOTS - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (new_game)   state_nxt = DRAW;
      DRAW:       if (last_store) state_nxt = DONE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the slot array is small and its EMPTY_DIGIT contents are architecturally visible, so it is reset like ordinary flops.
      for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= EMPTY_DIGIT;
      idx          <= 2'd0;
      rej_cnt      <= 8'd0;
      answer       <= 16'h0000;
      answer_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (new_game) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= EMPTY_DIGIT;
            idx          <= 2'd0;
            rej_cnt      <= 8'd0;
            answer_valid <= 1'b0;
            busy         <= 1'b1;
          end
        end
        DRAW: begin
          if (store) begin
            slot[idx] <= store_digit;
            idx       <= idx + 2'd1;
            rej_cnt   <= 8'd0;
            if (last_store) begin
              answer       <= {slot[0], slot[1], slot[2], store_digit};
              answer_valid <= 1'b1;
              busy         <= 1'b0;
            end
          end else begin
            rej_cnt <= rej_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_answer_generator.sv
// Scoreboard bench for answer_generator: default, alternate-seed and
// forced-fallback (REJECT_LIMIT=1, no zero) instances share one stimulus.
module tb_answer_generator;
  import bnc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, entropy, new_game;
  logic a_busy, a_valid, b_busy, b_valid, c_busy, c_valid;
  logic [15:0] a_ans, b_ans, c_ans;

  answer_generator u_a (
    .clk(clk), .rst(rst), .entropy(entropy), .new_game(new_game),
    .busy(a_busy), .answer_valid(a_valid), .answer(a_ans)
  );

  answer_generator #(.SEED(16'h0001)) u_b (
    .clk(clk), .rst(rst), .entropy(entropy), .new_game(new_game),
    .busy(b_busy), .answer_valid(b_valid), .answer(b_ans)
  );

  answer_generator #(.ALLOW_ZERO(1'b0), .REJECT_LIMIT(1)) u_c (
    .clk(clk), .rst(rst), .entropy(entropy), .new_game(new_game),
    .busy(c_busy), .answer_valid(c_valid), .answer(c_ans)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference LFSR, written from the algorithm description.
  function automatic logic [15:0] step(input logic [15:0] v, input logic d);
    logic [15:0] n;
    n = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    n[0] = n[0] ^ d;
    if (n == 16'h0000) n = 16'hACE1;
    return n;
  endfunction

  // Expected REJECT_LIMIT=1, no-zero answer for a draw whose start edge sees v0.
  function automatic logic [15:0] predict(input logic [15:0] v0);
    logic [15:0] v;
    logic [3:0]  dg [4];
    logic [3:0]  c;
    logic        ok, taken;
    v = v0;
    for (int k = 0; k < 4; k++) begin
      v  = step(v, 1'b0);
      c  = v[3:0];
      ok = (c >= 4'd1) && (c <= 4'd9);
      for (int j = 0; j < k; j++) if (dg[j] == c) ok = 1'b0;
      if (ok) dg[k] = c;
      else begin
        dg[k] = 4'hF;
        for (int d = 9; d >= 1; d--) begin
          taken = 1'b0;
          for (int j = 0; j < k; j++) if (dg[j] == 4'(d)) taken = 1'b1;
          if (!taken) dg[k] = 4'(d);
        end
      end
    end
    return {dg[0], dg[1], dg[2], dg[3]};
  endfunction

  function automatic bit all_illegal(input logic [15:0] v0);
    logic [15:0] v;
    v = v0;
    for (int k = 0; k < 4; k++) begin
      v = step(v, 1'b0);
      if (v[3:0] >= 4'd1 && v[3:0] <= 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit legal4(input logic [15:0] w);
    for (int i = 0; i < 4; i++) begin
      if (w[4*i +: 4] > 4'd9) return 1'b0;
      for (int j = 0; j < i; j++) if (w[4*i +: 4] == w[4*j +: 4]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit has_zero(input logic [15:0] w);
    for (int i = 0; i < 4; i++) if (w[4*i +: 4] == 4'd0) return 1'b1;
    return 1'b0;
  endfunction

  logic [15:0] m;
  logic        ms1, ms2;
  always @(posedge clk) begin
    if (rst) begin
      m <= 16'hACE1; ms1 <= 1'b0; ms2 <= 1'b0;
    end else begin
      ms1 <= entropy; ms2 <= ms1; m <= step(m, ms2);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] ans; int start; } exp_t;
  exp_t sb[$];

  logic c_prev = 1'b0, a_prev = 1'b0;
  int   a_busy_run = 0, a_last_busy = 0, a_rises = 0;

  always @(negedge clk) begin
    if (c_valid && !c_prev) begin
      if (sb.size() == 0) check("c_unexpected_done", 32'd1, 32'd0);
      else begin
        check("c_answer", 32'(c_ans), 32'(sb[0].ans));
        check("c_latency", 32'(cyc - sb[0].start), 32'd4);
        check("c_nozero", 32'(has_zero(c_ans)), 32'd0);
        void'(sb.pop_front());
      end
    end
    c_prev <= c_valid;
    if (a_busy) a_busy_run <= a_busy_run + 1;
    else        a_busy_run <= 0;
    if (a_valid && !a_prev) begin
      check("a_legal", 32'(legal4(a_ans)), 32'd1);
      a_last_busy <= a_busy_run;
      a_rises     <= a_rises + 1;
    end
    a_prev <= a_valid;
  end

  int a_start = 0;

  task automatic start_game();
    exp_t e;
    new_game = 1'b1;
    a_start  = cyc + 1;
    e.ans    = predict(m);
    e.start  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    new_game = 1'b0;
  endtask

  task automatic wait_a_done(input string tag, output int lat);
    int n;
    n = 0;
    while (!a_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(a_valid), 32'd1);
    lat = cyc - a_start;
  endtask

  task automatic det_run(output logic [15:0] ans_a, output int lat_a, output logic [15:0] ans_b);
    logic [19:0] pat;
    int n;
    pat = 20'hB3A5C;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 20; i++) begin
      entropy = pat[i];
      @(negedge clk);
    end
    entropy = 1'b0;
    repeat (4) @(negedge clk);
    start_game();
    wait_a_done("det_a_timeout", lat_a);
    ans_a = a_ans;
    n = 0;
    while (!b_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("det_b_timeout", 32'(b_valid), 32'd1);
    ans_b = b_ans;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [15:0] ans1, ans2, b1, b2, v, keep;
    int lat, lat1, lat2, k, hi, r0;
    bit found;
    exp_t e;

    rst = 1'b1; new_game = 1'b1; entropy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_answer", 32'(a_ans), 32'h0);
      check("rst_valid", 32'(a_valid), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_c_busy", 32'(c_busy), 32'd0);
    end
    check("rst_lfsr", 32'(u_a.u_lfsr.q), 32'hACE1);
    rst = 1'b0; new_game = 1'b0;
    repeat (3) @(negedge clk);

    // Normal draw
    start_game();
    check("draw_busy", 32'(a_busy), 32'd1);
    check("draw_valid_low", 32'(a_valid), 32'd0);
    wait_a_done("normal_timeout", lat);
    check("normal_lat_range", 32'(lat >= 4 && lat <= 256), 32'd1);
    @(negedge clk);
    check("normal_busy_len", 32'(a_last_busy), 32'(lat));

    // Determinism and seed sensitivity
    det_run(ans1, lat1, b1);
    det_run(ans2, lat2, b2);
    check("det_answer", 32'(ans2), 32'(ans1));
    check("det_latency", 32'(lat2), 32'(lat1));
    check("seed_differs", 32'(b1 != ans1), 32'd1);

    // Every first candidate illegal -> fallback fills 1,2,3,4
    v = m; found = 1'b0; k = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      if (all_illegal(v)) found = 1'b1;
      else begin v = step(v, 1'b0); k++; end
    end
    check("illegal_window_found", 32'(found), 32'd1);
    repeat (k) @(negedge clk);
    start_game();
    repeat (5) @(negedge clk);
    check("c_all_illegal", 32'(c_ans), 32'h1234);
    wait_a_done("fallback_a_timeout", lat);
    @(negedge clk);

    // new_game held: back-to-back redraws, DONE visible one cycle each
    v = m;
    for (int r = 0; r < 4; r++) begin
      e.ans = predict(v);
      e.start = cyc + 1 + 5 * r;
      sb.push_back(e);
      for (int s = 0; s < 5; s++) v = step(v, 1'b0);
    end
    new_game = 1'b1;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (c_valid) hi++;
    end
    new_game = 1'b0;
    check("held_done_cycles", 32'(hi), 32'd4);
    a_start = cyc;
    wait_a_done("held_a_timeout", lat);
    repeat (2) @(negedge clk);

    // Collision: second pulse two cycles into the draw is ignored
    r0 = a_rises;
    start_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    wait_a_done("col_timeout", lat);
    keep = a_ans;
    repeat (10) @(negedge clk);
    check("col_single_done", 32'(a_rises - r0), 32'd1);
    check("col_answer_held", 32'(a_ans), 32'(keep));
    check("col_valid_held", 32'(a_valid), 32'd1);

    // Reset in the middle of a draw
    start_game();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_idle", 32'(u_a.state), 32'(IDLE));
    check("mid_rst_answer", 32'(a_ans), 32'h0);
    check("mid_rst_valid", 32'(a_valid), 32'd0);
    check("mid_rst_busy", 32'(a_busy), 32'd0);
    check("mid_rst_c_answer", 32'(c_ans), 32'h0);
    rst = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    start_game();
    wait_a_done("post_rst_timeout", lat);
    check("post_rst_lat_range", 32'(lat >= 4 && lat <= 256), 32'd1);
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
